// File: rtl/fifo_wr_sched_pkg.sv
// rtl/fifo_wr_sched_pkg.sv - shared defaults and state encoding for the ADC FIFO write scheduler
package fifo_wr_sched_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DW     = 16;
    localparam int DEF_TO_CYC = 255;
    localparam int TMR_W      = 8;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_SCAN  = 5'b00010,
        S_WAITD = 5'b00100,
        S_REL   = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

endpackage

// File: rtl/fifo_wr_sched.sv
// rtl/fifo_wr_sched.sv - serialises per-channel ADC writers onto one shared FIFO pair
module fifo_wr_sched
    import fifo_wr_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DW     = DEF_DW,
    parameter int TO_CYC = DEF_TO_CYC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic [NUM_CH-1:0]    ch_mask,
    output logic [NUM_CH-1:0]    ch_fs,
    input  logic [NUM_CH-1:0]    ch_fd,
    input  logic [2*NUM_CH-1:0]  ch_txen,
    input  logic [NUM_CH*DW-1:0] ch_txd,
    output logic [1:0]           fifo_txen,
    output logic [DW-1:0]        fifo_txd,
    output logic                 busy,
    output logic                 frame_done,
    output logic [NUM_CH-1:0]    to_err,
    output logic                 overrun,
    input  logic                 err_clr
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [TMR_W-1:0] TO_LAST = TMR_W'(TO_CYC - 1);

    state_t             r_state, w_state_nx;
    logic [NUM_CH-1:0]  r_pend, w_pend_nx;
    logic [IW-1:0]      r_ch_idx, w_ch_idx_nx, w_pick;
    logic [TMR_W-1:0]   r_timer, w_timer_nx, w_timer_inc;
    logic [NUM_CH-1:0]  r_to_err, w_to_err_set, w_sel_oh;
    logic               r_overrun;
    logic               w_fd_sel, w_tmo, w_mux_en;

    always_comb begin
        w_pick = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_pend[i]) w_pick = IW'(i);
        end
    end

    always_comb begin
        w_sel_oh = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_sel_oh[i] = (r_ch_idx == IW'(i));
        end
    end

    assign w_fd_sel    = |(ch_fd & w_sel_oh);
    assign w_tmo       = (r_timer == TO_LAST);
    assign w_timer_inc = (r_timer == {TMR_W{1'b1}}) ? r_timer : r_timer + TMR_W'(1);

    always_comb begin
        w_state_nx   = r_state;
        w_pend_nx    = r_pend;
        w_ch_idx_nx  = r_ch_idx;
        w_timer_nx   = r_timer;
        w_to_err_set = '0;
        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_pend_nx  = ch_mask;
                    w_state_nx = S_SCAN;
                end
            end
            S_SCAN: begin
                if (|r_pend) begin
                    w_ch_idx_nx = w_pick;
                    // x & (x-1) clears exactly the lowest set bit, matching w_pick
                    w_pend_nx   = r_pend & (r_pend - NUM_CH'(1));
                    w_timer_nx  = '0;
                    w_state_nx  = S_WAITD;
                end else begin
                    w_state_nx = S_DONE;
                end
            end
            S_WAITD: begin
                w_timer_nx = w_timer_inc;
                if (w_fd_sel) begin
                    w_timer_nx = '0;
                    w_state_nx = S_REL;
                end else if (w_tmo) begin
                    w_to_err_set = w_sel_oh;
                    w_timer_nx   = '0;
                    w_state_nx   = S_REL;
                end
            end
            S_REL: begin
                w_timer_nx = w_timer_inc;
                if (!w_fd_sel) begin
                    w_state_nx = S_SCAN;
                end else if (w_tmo) begin
                    w_to_err_set = w_sel_oh;
                    w_state_nx   = S_SCAN;
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pend    <= '0;
            r_ch_idx  <= '0;
            r_timer   <= '0;
            r_to_err  <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_pend   <= w_pend_nx;
            r_ch_idx <= w_ch_idx_nx;
            r_timer  <= w_timer_nx;
            if (err_clr) begin
                r_to_err  <= '0;
                r_overrun <= 1'b0;
            end else begin
                r_to_err <= r_to_err | w_to_err_set;
                if (frame_start && (r_state != S_IDLE)) r_overrun <= 1'b1;
            end
        end
    end

    assign w_mux_en = (r_state == S_WAITD) || (r_state == S_REL);

    always_comb begin
        fifo_txen = '0;
        fifo_txd  = '0;
        if (w_mux_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_sel_oh[i]) begin
                    fifo_txen = ch_txen[2*i +: 2];
                    fifo_txd  = ch_txd[DW*i +: DW];
                end
            end
        end
    end

    assign ch_fs      = (r_state == S_WAITD) ? w_sel_oh : '0;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = (r_state == S_DONE);
    assign to_err     = r_to_err;
    assign overrun    = r_overrun;

endmodule
